// File: rtl/pong_pkg.sv
// Shared definitions for the pong score keeper: FSM encoding, 7-segment
// glyphs (active-low {g,f,e,d,c,b,a}) and a BCD increment helper.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Two-digit BCD +1; units carry into tens, tens 9 wraps to 0.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low segments; blank or non-decimal codes go dark.
module bcd_to_7seg
  import pong_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: miss edge detect, BCD scores, serve/hold/over
// sequencing and a 4-digit multiplexed display showing LLRR.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter logic [7:0] WIN_SCORE    = 8'h11,
  parameter int         HOLD_FRAMES  = 120,
  parameter int         REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_miss,
  input  logic       right_miss,
  input  logic       rescan,
  input  logic       new_game,
  output logic       serve_hold,
  output logic       game_over,
  output logic       winner,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD_FRAMES);

  state_e                  state;
  logic [7:0]              hold_cnt;
  logic                    lm_q, lm_prev, rm_q, rm_prev;
  logic                    l_edge, r_edge;
  logic [7:0]              nxt_left, nxt_right;
  logic                    blink;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    digit_blank;
  logic [6:0]              glyph;

  assign l_edge    = lm_q & ~lm_prev;
  assign r_edge    = rm_q & ~rm_prev;
  assign nxt_left  = bcd_inc(score_left);
  assign nxt_right = bcd_inc(score_right);

  // Register the miss levels once, then keep a previous copy for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      lm_q <= 1'b0; lm_prev <= 1'b0;
      rm_q <= 1'b0; rm_prev <= 1'b0;
    end else begin
      lm_q <= left_miss;  lm_prev <= lm_q;
      rm_q <= right_miss; rm_prev <= rm_q;
    end
  end

  // Game FSM with scores, hold counter and registered status outputs
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state       <= ST_HOLD;
      hold_cnt    <= HOLD_CNT;
      serve_hold  <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      score_left  <= 8'h00;
      score_right <= 8'h00;
    end else begin
      case (state)
        ST_PLAY: begin
          if (l_edge || r_edge) begin
            state      <= ST_HOLD;
            hold_cnt   <= HOLD_CNT;
            serve_hold <= 1'b1;
            // simultaneous exits are a dead ball: re-serve without scoring
            if (r_edge && !l_edge) begin
              score_left <= nxt_left;
              if (nxt_left == WIN_SCORE) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end
            end else if (l_edge && !r_edge) begin
              score_right <= nxt_right;
              if (nxt_right == WIN_SCORE) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (rescan) begin
            if (hold_cnt == 8'd1) begin
              state      <= ST_PLAY;
              serve_hold <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
        end
        ST_OVER: ;
        default: begin
          state      <= ST_HOLD;
          hold_cnt   <= HOLD_CNT;
          serve_hold <= 1'b1;
        end
      endcase
    end
  end

  // Loser-digit flash phase: toggles each frame while the game is over
  always_ff @(posedge clk) begin
    if (rst || !game_over) blink <= 1'b0;
    else if (rescan)       blink <= ~blink;
  end

  // Free-running display refresh counter
  always_ff @(posedge clk) begin
    if (rst) refresh_cnt <= '0;
    else     refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  // Pick the digit for the current position; leading-zero tens are dark
  always_comb begin
    digit       = 4'd0;
    digit_blank = 1'b1;
    case (sel)
      2'd3: begin
        digit       = score_left[7:4];
        digit_blank = (score_left[7:4] == 4'd0) || (game_over && blink && winner);
      end
      2'd2: begin
        digit       = score_left[3:0];
        digit_blank = game_over && blink && winner;
      end
      2'd1: begin
        digit       = score_right[7:4];
        digit_blank = (score_right[7:4] == 4'd0) || (game_over && blink && !winner);
      end
      default: begin
        digit       = score_right[3:0];
        digit_blank = game_over && blink && !winner;
      end
    endcase
  end

  bcd_to_7seg u_seg (
    .bcd   (digit),
    .blank (digit_blank),
    .seg   (glyph)
  );

  // Registered display drive; the point after the left units separates scores
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= glyph;
      dp  <= (sel != 2'd2);
    end
  end

endmodule
